// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing with memory handshakes.
// Define MC_PERF_COUNTERS_EN to build the cycle/instret performance counters.
module multicycle_control #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             ebreak_imm,
    input  logic             ALUzero,
    input  logic             ALUneg,
    input  logic             im_ready,
    input  logic             dm_ready,
    output logic             im_req,
    output logic             dm_req,
    output logic             dm_we,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             ALUsrc,
    output logic [3:0]       ALUctl,
    output logic [1:0]       PCsrc,
    output logic [2:0]       MemtoReg,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StTrap
    } state_e;

    state_e           state_q;
    logic [WaitW-1:0] wait_q;
    logic             resume_armed_q;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic is_opimm, is_op, is_ebreak, is_legal, branch_bad, branch_taken;
    logic wait_expired;
    logic [3:0] alu_ctl;

    always_comb begin
        is_lui     = (opcode == OpLui);
        is_auipc   = (opcode == OpAuipc);
        is_jal     = (opcode == OpJal);
        is_jalr    = (opcode == OpJalr);
        is_branch  = (opcode == OpBranch);
        is_load    = (opcode == OpLoad);
        is_store   = (opcode == OpStore);
        is_opimm   = (opcode == OpImm);
        is_op      = (opcode == OpReg);
        is_ebreak  = (opcode == OpSystem) && ebreak_imm;
        is_legal   = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                     is_opimm | is_op;
        branch_bad = is_branch && (funct3[2:1] == 2'b01);

        // Unsigned branches reuse the signed flag; the datapath only provides one compare.
        case (funct3)
            3'b000:          branch_taken = ALUzero;
            3'b001:          branch_taken = !ALUzero;
            3'b100, 3'b110:  branch_taken = ALUneg;
            3'b101, 3'b111:  branch_taken = !ALUneg;
            default:         branch_taken = 1'b0;
        endcase

        if (is_op) begin
            alu_ctl = {funct7_5, funct3};
        end else if (is_opimm) begin
            alu_ctl = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
        end else if (is_branch) begin
            alu_ctl = 4'b1000;
        end else begin
            alu_ctl = 4'b0000;
        end

        wait_expired = (MAX_WAIT != 0) && (wait_q == WaitLast);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            wait_q         <= '0;
            resume_armed_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q <= StFetch;
                        wait_q  <= '0;
                    end
                end
                StFetch: begin
                    if (im_ready) begin
                        state_q <= StDecode;
                    end else if (wait_expired) begin
                        state_q <= StTrap;
                    end else if (MAX_WAIT != 0) begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StDecode: begin
                    if (is_ebreak) begin
                        state_q        <= StHalt;
                        resume_armed_q <= 1'b0;
                    end else if (!is_legal || branch_bad) begin
                        state_q <= StTrap;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (is_branch) begin
                        state_q <= StFetch;
                        wait_q  <= '0;
                    end else if (is_load || is_store) begin
                        state_q <= StMem;
                        wait_q  <= '0;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    if (dm_ready) begin
                        if (is_store) begin
                            state_q <= StFetch;
                            wait_q  <= '0;
                        end else begin
                            state_q <= StWb;
                        end
                    end else if (wait_expired) begin
                        state_q <= StTrap;
                    end else if (MAX_WAIT != 0) begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StWb: begin
                    state_q <= StFetch;
                    wait_q  <= '0;
                end
                StHalt: begin
                    // Resume needs a fresh rising level of run, not the one that was held.
                    if (!run) begin
                        resume_armed_q <= 1'b1;
                    end else if (resume_armed_q) begin
                        state_q        <= StFetch;
                        wait_q         <= '0;
                        resume_armed_q <= 1'b0;
                    end
                end
                StTrap: begin
                    state_q <= StTrap;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        im_req   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        ALUsrc   = 1'b0;
        ALUctl   = 4'b0000;
        PCsrc    = 2'b00;
        MemtoReg = 3'b000;
        case (state_q)
            StFetch: begin
                im_req  = 1'b1;
                IRWrite = im_ready;
            end
            StDecode: begin
                PCWrite = is_ebreak;
            end
            StExec: begin
                ALUsrc = !(is_op || is_branch);
                ALUctl = alu_ctl;
                if (is_branch) begin
                    PCWrite = 1'b1;
                    PCsrc   = branch_taken ? 2'b01 : 2'b00;
                end
            end
            StMem: begin
                dm_req  = 1'b1;
                dm_we   = is_store;
                ALUsrc  = 1'b1;
                PCWrite = is_store && dm_ready;
            end
            StWb: begin
                // ALU controls stay applied so jalr's target is still on the ALU output.
                ALUsrc   = !is_op;
                ALUctl   = alu_ctl;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                if (is_jal) begin
                    PCsrc = 2'b01;
                end else if (is_jalr) begin
                    PCsrc = 2'b10;
                end
                if (is_load) begin
                    MemtoReg = 3'b001;
                end else if (is_jal || is_jalr) begin
                    MemtoReg = 3'b010;
                end else if (is_lui) begin
                    MemtoReg = 3'b011;
                end else if (is_auipc) begin
                    MemtoReg = 3'b100;
                end
            end
            default: begin
            end
        endcase
    end

    assign halted = (state_q == StHalt);
    assign trap   = (state_q == StTrap);

`ifdef MC_PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != StIdle && state_q != StHalt && state_q != StTrap) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (PCWrite) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (MAX_WAIT=4) over a small RV32I program.
module tb_multicycle_control;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             run = 1'b0;
    logic [6:0]       opcode = '0;
    logic [2:0]       funct3 = '0;
    logic             funct7_5 = 1'b0;
    logic             ebreak_imm = 1'b0;
    logic             ALUzero = 1'b0;
    logic             ALUneg = 1'b0;
    logic             im_ready = 1'b0;
    logic             dm_ready = 1'b0;
    logic             im_req, dm_req, dm_we, IRWrite, PCWrite, RegWrite, ALUsrc;
    logic [3:0]       ALUctl;
    logic [1:0]       PCsrc;
    logic [2:0]       MemtoReg;
    logic             halted, trap;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .ebreak_imm(ebreak_imm), .ALUzero(ALUzero), .ALUneg(ALUneg),
        .im_ready(im_ready), .dm_ready(dm_ready), .im_req(im_req), .dm_req(dm_req),
        .dm_we(dm_we), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUsrc(ALUsrc), .ALUctl(ALUctl), .PCsrc(PCsrc), .MemtoReg(MemtoReg),
        .halted(halted), .trap(trap), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [31:0] w);
        opcode     = w[6:0];
        funct3     = w[14:12];
        funct7_5   = w[30];
        ebreak_imm = w[20];
    endtask

    function automatic logic [20:0] all_outs();
        return {im_req, dm_req, dm_we, IRWrite, PCWrite, RegWrite, ALUsrc, ALUctl, PCsrc,
                MemtoReg, halted, trap};
    endfunction

    task automatic test_reset();
        next_cycle();
        next_cycle();
        sample();
        total++;
        if (all_outs() !== 21'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        total++;
        if (cycle_cnt !== '0 || instret_cnt !== '0) begin
            bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
        end
        next_cycle();
        rst = 1'b1;
        sample();
        total++;
        if (all_outs() !== 21'd0) begin
            bad++; $display("FAIL idle_no_run: got %h want 0", all_outs());
        end
    endtask

    task automatic test_add();
        next_cycle();
        run = 1'b1; im_ready = 1'b1; set_instr(32'h0000_0033);
        sample();
        total++;
        if (im_req !== 1'b0) begin
            bad++; $display("FAIL idle_im_req: got %b want 0", im_req);
        end
        next_cycle(); sample();
        total++;
        if (im_req !== 1'b1 || IRWrite !== 1'b1) begin
            bad++; $display("FAIL add_fetch: im_req=%b IRWrite=%b want 1 1", im_req, IRWrite);
        end
        next_cycle(); sample();
        total++;
        if (IRWrite !== 1'b0 || im_req !== 1'b0 || PCWrite !== 1'b0) begin
            bad++; $display("FAIL add_decode: IRWrite=%b im_req=%b PCWrite=%b want 0 0 0",
                            IRWrite, im_req, PCWrite);
        end
        next_cycle(); sample();
        total++;
        if (ALUsrc !== 1'b0 || ALUctl !== 4'b0000 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin
            bad++; $display("FAIL add_exec: ALUsrc=%b ALUctl=%b RegWrite=%b PCWrite=%b want 0 0000 0 0",
                            ALUsrc, ALUctl, RegWrite, PCWrite);
        end
        next_cycle(); sample();
        total++;
        if (RegWrite !== 1'b1 || PCWrite !== 1'b1 || MemtoReg !== 3'b000 || PCsrc !== 2'b00) begin
            bad++; $display("FAIL add_wb: RegWrite=%b PCWrite=%b MemtoReg=%b PCsrc=%b want 1 1 000 00",
                            RegWrite, PCWrite, MemtoReg, PCsrc);
        end
    endtask

    task automatic test_sub_srai();
        logic [31:0] instr [2]   = '{32'h4000_0033, 32'h4000_5013};
        logic [3:0]  exp_ctl [2] = '{4'b1000, 4'b1101};
        logic        exp_src [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            next_cycle(); set_instr(instr[i]); sample();
            total++;
            if (IRWrite !== 1'b1) begin
                bad++; $display("FAIL alu%0d_fetch: IRWrite=%b want 1", i, IRWrite);
            end
            next_cycle();
            next_cycle(); sample();
            total++;
            if (ALUctl !== exp_ctl[i] || ALUsrc !== exp_src[i]) begin
                bad++; $display("FAIL alu%0d_exec: ALUctl=%b ALUsrc=%b want %b %b",
                                i, ALUctl, ALUsrc, exp_ctl[i], exp_src[i]);
            end
            next_cycle(); sample();
            total++;
            if (RegWrite !== 1'b1 || PCWrite !== 1'b1) begin
                bad++; $display("FAIL alu%0d_wb: RegWrite=%b PCWrite=%b want 1 1", i, RegWrite, PCWrite);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] instr [3]   = '{32'h0000_0063, 32'h0000_1063, 32'h0000_4063};
        logic        zero [3]    = '{1'b1, 1'b1, 1'b0};
        logic        neg [3]     = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  exp_src [3] = '{2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 3; i++) begin
            next_cycle(); set_instr(instr[i]); ALUzero = zero[i]; ALUneg = neg[i];
            next_cycle();
            next_cycle(); sample();
            total++;
            if (PCWrite !== 1'b1 || PCsrc !== exp_src[i] || RegWrite !== 1'b0 ||
                ALUctl !== 4'b1000 || ALUsrc !== 1'b0) begin
                bad++; $display("FAIL br%0d_exec: PCWrite=%b PCsrc=%b RegWrite=%b ALUctl=%b ALUsrc=%b want 1 %b 0 1000 0",
                                i, PCWrite, PCsrc, RegWrite, ALUctl, ALUsrc, exp_src[i]);
            end
        end
        ALUzero = 1'b0; ALUneg = 1'b0;
    endtask

    task automatic test_load_store();
        next_cycle(); set_instr(32'h0000_2003); sample();
        total++;
        if (im_req !== 1'b1) begin
            bad++; $display("FAIL after_branch_fetch: im_req=%b want 1", im_req);
        end
        next_cycle();
        next_cycle(); sample();
        total++;
        if (ALUctl !== 4'b0000 || ALUsrc !== 1'b1 || PCWrite !== 1'b0) begin
            bad++; $display("FAIL lw_exec: ALUctl=%b ALUsrc=%b PCWrite=%b want 0000 1 0",
                            ALUctl, ALUsrc, PCWrite);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle(); dm_ready = 1'b0; sample();
            total++;
            if (dm_req !== 1'b1 || dm_we !== 1'b0) begin
                bad++; $display("FAIL lw_wait%0d: dm_req=%b dm_we=%b want 1 0", i, dm_req, dm_we);
            end
        end
        // Ready lands on the cycle the wait counter reaches its limit: ready must win.
        next_cycle(); dm_ready = 1'b1; sample();
        total++;
        if (dm_req !== 1'b1 || PCWrite !== 1'b0 || RegWrite !== 1'b0 || trap !== 1'b0) begin
            bad++; $display("FAIL lw_ready: dm_req=%b PCWrite=%b RegWrite=%b trap=%b want 1 0 0 0",
                            dm_req, PCWrite, RegWrite, trap);
        end
        next_cycle(); dm_ready = 1'b0; sample();
        total++;
        if (MemtoReg !== 3'b001 || RegWrite !== 1'b1 || PCWrite !== 1'b1 || dm_req !== 1'b0) begin
            bad++; $display("FAIL lw_wb: MemtoReg=%b RegWrite=%b PCWrite=%b dm_req=%b want 001 1 1 0",
                            MemtoReg, RegWrite, PCWrite, dm_req);
        end
        next_cycle(); set_instr(32'h0000_2023);
        next_cycle();
        next_cycle();
        next_cycle(); dm_ready = 1'b1; sample();
        total++;
        if (dm_req !== 1'b1 || dm_we !== 1'b1 || PCWrite !== 1'b1 || PCsrc !== 2'b00 ||
            RegWrite !== 1'b0) begin
            bad++; $display("FAIL sw_mem: dm_req=%b dm_we=%b PCWrite=%b PCsrc=%b RegWrite=%b want 1 1 1 00 0",
                            dm_req, dm_we, PCWrite, PCsrc, RegWrite);
        end
    endtask

    task automatic test_ebreak();
        logic [CNT_W-1:0] exp_cycles, exp_instret;
`ifdef MC_PERF_COUNTERS_EN
        exp_cycles  = 35;
        exp_instret = 9;
`else
        exp_cycles  = 0;
        exp_instret = 0;
`endif
        next_cycle(); dm_ready = 1'b0; set_instr(32'h0010_0073);
        next_cycle(); sample();
        total++;
        if (PCWrite !== 1'b1 || PCsrc !== 2'b00 || RegWrite !== 1'b0 || halted !== 1'b0) begin
            bad++; $display("FAIL ebreak_decode: PCWrite=%b PCsrc=%b RegWrite=%b halted=%b want 1 00 0 0",
                            PCWrite, PCsrc, RegWrite, halted);
        end
        next_cycle(); sample();
        total++;
        if (halted !== 1'b1 || PCWrite !== 1'b0 || im_req !== 1'b0) begin
            bad++; $display("FAIL halt_state: halted=%b PCWrite=%b im_req=%b want 1 0 0",
                            halted, PCWrite, im_req);
        end
        total++;
        if (cycle_cnt !== exp_cycles || instret_cnt !== exp_instret) begin
            bad++; $display("FAIL perf_counters: cycle=%0d instret=%0d want %0d %0d",
                            cycle_cnt, instret_cnt, exp_cycles, exp_instret);
        end
        next_cycle(); sample();
        total++;
        if (halted !== 1'b1) begin
            bad++; $display("FAIL halt_run_held: halted=%b want 1", halted);
        end
        next_cycle(); run = 1'b0;
        next_cycle(); run = 1'b1; im_ready = 1'b0; sample();
        total++;
        if (halted !== 1'b1 || im_req !== 1'b0) begin
            bad++; $display("FAIL halt_rearm: halted=%b im_req=%b want 1 0", halted, im_req);
        end
        next_cycle(); sample();
        total++;
        if (halted !== 1'b0 || im_req !== 1'b1) begin
            bad++; $display("FAIL resume_fetch: halted=%b im_req=%b want 0 1", halted, im_req);
        end
    endtask

    task automatic test_timeout();
        // First stalled fetch cycle was the resume cycle; three more before the trap.
        for (int i = 0; i < 3; i++) begin
            next_cycle(); sample();
            total++;
            if (im_req !== 1'b1 || trap !== 1'b0) begin
                bad++; $display("FAIL timeout_wait%0d: im_req=%b trap=%b want 1 0", i, im_req, trap);
            end
        end
        next_cycle(); sample();
        total++;
        if (trap !== 1'b1 || im_req !== 1'b0 || IRWrite !== 1'b0) begin
            bad++; $display("FAIL timeout_trap: trap=%b im_req=%b IRWrite=%b want 1 0 0",
                            trap, im_req, IRWrite);
        end
        next_cycle(); run = 1'b0; im_ready = 1'b1;
        next_cycle(); run = 1'b1; sample();
        total++;
        if (trap !== 1'b1 || im_req !== 1'b0) begin
            bad++; $display("FAIL trap_sticky: trap=%b im_req=%b want 1 0", trap, im_req);
        end
        next_cycle(); rst = 1'b0; #1;
        total++;
        if (all_outs() !== 21'd0 || cycle_cnt !== '0 || instret_cnt !== '0) begin
            bad++; $display("FAIL async_reset: outs=%h cycle=%0d instret=%0d want 0 0 0",
                            all_outs(), cycle_cnt, instret_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] instr [2] = '{32'h0000_2063, 32'h0000_000b};
        for (int i = 0; i < 2; i++) begin
            next_cycle(); rst = 1'b0;
            next_cycle(); rst = 1'b1; run = 1'b0; im_ready = 1'b1; dm_ready = 1'b1; sample();
            total++;
            if (IRWrite !== 1'b0 || dm_req !== 1'b0 || im_req !== 1'b0) begin
                bad++; $display("FAIL ill%0d_idle_ready: IRWrite=%b dm_req=%b im_req=%b want 0 0 0",
                                i, IRWrite, dm_req, im_req);
            end
            next_cycle(); run = 1'b1; dm_ready = 1'b0; set_instr(instr[i]);
            next_cycle(); sample();
            total++;
            if (IRWrite !== 1'b1) begin
                bad++; $display("FAIL ill%0d_fetch: IRWrite=%b want 1", i, IRWrite);
            end
            next_cycle(); sample();
            total++;
            if (PCWrite !== 1'b0 || trap !== 1'b0) begin
                bad++; $display("FAIL ill%0d_decode: PCWrite=%b trap=%b want 0 0", i, PCWrite, trap);
            end
            next_cycle(); sample();
            total++;
            if (trap !== 1'b1 || RegWrite !== 1'b0 || im_req !== 1'b0) begin
                bad++; $display("FAIL ill%0d_trap: trap=%b RegWrite=%b im_req=%b want 1 0 0",
                                i, trap, RegWrite, im_req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_srai();
        test_branch();
        test_load_store();
        test_ebreak();
        test_timeout();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
